// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: pointer-width calculation and Gray encode/decode.
// Latency: none. These are pure functions used at elaboration time or in combinational logic.
// Backpressure: not applicable. The package holds no state and no flow control.
package fifo_pkg;

    // Widest pointer the Gray helpers handle. Callers size-cast to their own width.
    localparam int unsigned GRAY_W = 32;

    // Ceiling log2 for sizing address fields. A depth of 1 gives 0 bits.
    function automatic int unsigned clog2(input int unsigned val);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (((val - 1) >> i) != 0) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

    // Default geometry shared by the read and write controllers.
    localparam int unsigned DEF_DEPTH     = 1024;
    localparam int unsigned DEF_ADDR_BITS = clog2(DEF_DEPTH);

    // Binary to reflected Gray. Adjacent binary values differ in exactly one Gray bit.
    function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Reflected Gray to binary, for the far side of the pointer synchroniser.
    function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] gray);
        logic [GRAY_W-1:0] bin;
        bin[GRAY_W-1] = gray[GRAY_W-1];
        for (int i = GRAY_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry valid/ready output buffer. The head entry drives head_data.
// Latency: a word pushed in cycle T is at the head in T+1 if the buffer was empty.
// Backpressure: a push into a full buffer without a pop is ignored, so the producer must gate on count.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int unsigned P_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [P_WIDTH-1:0] push_data,
    input  logic               pop,
    output logic [1:0]         count,
    output logic [P_WIDTH-1:0] head_data
);

    logic [P_WIDTH-1:0] ent0_q, ent0_d;
    logic [P_WIDTH-1:0] ent1_q, ent1_d;
    logic [1:0]         cnt_q, cnt_d;
    logic               pop_eff;
    logic               push_eff;

    // Only pop a word that exists. Only push when there is room now or a pop frees a slot.
    assign pop_eff  = pop && (cnt_q != 2'd0);
    assign push_eff = push && ((cnt_q != 2'd2) || pop_eff);

    // Next-state for the entries and the count. ent0 is always the head.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        cnt_d  = cnt_q;
        case ({push_eff, pop_eff})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    ent0_d = push_data;
                end else begin
                    ent1_d = push_data;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                // The count is unchanged. With two words held, the second shifts up
                // and the new word takes the tail.
                if (cnt_q == 2'd2) begin
                    ent0_d = ent1_q;
                    ent1_d = push_data;
                end else begin
                    ent0_d = push_data;
                end
            end
            default: begin
            end
        endcase
    end

    // Register the entries and the count. Reset empties the buffer and clears the head.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent0_q <= '0;
            ent1_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            cnt_q  <= cnt_d;
        end
    end

    assign count     = cnt_q;
    assign head_data = ent0_q;

endmodule

// File: rtl/fifo_fwft_rd_ctrl.sv
// FIFO read-side controller: owns rd_ptr, drives the BRAM read address and presents a first-word-fall-through stream.
// Latency: wr_ptr_sync moving ahead in cycle T gives m_valid in T+2. One word per cycle is sustained after that.
// Backpressure: while m_ready is low, reads stop once buffered plus in-flight words reach two. No word is lost.
module fifo_fwft_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned  P_DEPTH   = 1024,
    parameter int unsigned  P_WIDTH   = 8,
    localparam int unsigned ADDR_BITS = clog2(P_DEPTH),
    localparam int unsigned PTR_W     = ADDR_BITS + 1
) (
    input  logic                 rd_clk,
    input  logic                 rd_rst_n,
    input  logic [PTR_W-1:0]     wr_ptr_sync,
    output logic [ADDR_BITS-1:0] bram_rd_addr,
    input  logic [P_WIDTH-1:0]   bram_rd_data,
    output logic [P_WIDTH-1:0]   m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [PTR_W-1:0]     rd_ptr,
    output logic [PTR_W-1:0]     rd_ptr_gray,
    output logic [PTR_W-1:0]     rd_level
);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] rd_ptr_gray_q, rd_ptr_gray_d;
    logic             inflight_q, inflight_d;
    logic [1:0]       buf_cnt;
    logic             empty_mem;
    logic             pop;
    logic             issue;
    logic [2:0]       occ_now;
    logic [2:0]       occ_limit;

    // The memory holds unread words whenever the pointers differ, including the full case
    // where only the wrap bits differ.
    assign empty_mem = (wr_ptr_sync == rd_ptr_q);

    assign m_valid = (buf_cnt != 2'd0);
    assign pop     = m_valid && m_ready;

    // Issue only if the word returning next cycle is sure to find a free buffer slot.
    // buf_cnt + inflight - pop <= 1 is rewritten as buf_cnt + inflight <= 1 + pop to avoid underflow.
    assign occ_now   = {1'b0, buf_cnt} + {2'b00, inflight_q};
    assign occ_limit = 3'd1 + {2'b00, pop};
    assign issue     = !empty_mem && (occ_now <= occ_limit);

    // Next read pointer, in-flight flag and Gray image of the next pointer.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        inflight_d = 1'b0;
        if (issue) begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            inflight_d = 1'b1;
        end
        rd_ptr_gray_d = PTR_W'(bin2gray(32'(rd_ptr_d)));
    end

    // Pointer, Gray and in-flight registers. Reset discards any read in progress.
    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            rd_ptr_q      <= '0;
            rd_ptr_gray_q <= '0;
            inflight_q    <= 1'b0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            rd_ptr_gray_q <= rd_ptr_gray_d;
            inflight_q    <= inflight_d;
        end
    end

    // The BRAM registers its read, so data for last cycle's address arrives while inflight_q is set.
    fifo_skid_buf #(
        .P_WIDTH (P_WIDTH)
    ) u_skid_buf (
        .clk       (rd_clk),
        .rst_n     (rd_rst_n),
        .push      (inflight_q),
        .push_data (bram_rd_data),
        .pop       (pop),
        .count     (buf_cnt),
        .head_data (m_data)
    );

    assign bram_rd_addr = rd_ptr_q[ADDR_BITS-1:0];
    assign rd_ptr       = rd_ptr_q;
    assign rd_ptr_gray  = rd_ptr_gray_q;

    // Level counts words not yet handed to the consumer: unissued, in flight and buffered.
    assign rd_level = (wr_ptr_sync - rd_ptr_q) + PTR_W'(inflight_q) + PTR_W'(buf_cnt);

endmodule

// File: tb/tb_fifo_fwft_rd_ctrl.sv
// Bench for fifo_fwft_rd_ctrl: a BRAM model with a registered read and a word-order scoreboard.
// Inputs change on the falling edge, and outputs are sampled 1 ns later.
// The consumer's m_ready is driven directed or random.
module tb_fifo_fwft_rd_ctrl;

    localparam int D  = 1024;
    localparam int AB = 10;
    localparam int PW = AB + 1;

    logic          rd_clk = 1'b0;
    logic          rd_rst_n = 1'b0;
    logic [PW-1:0] wr_ptr_sync = '0;
    logic [AB-1:0] bram_rd_addr;
    logic [7:0]    bram_rd_data;
    logic [7:0]    m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_ptr_gray;
    logic [PW-1:0] rd_level;

    fifo_fwft_rd_ctrl #(.P_DEPTH(D), .P_WIDTH(8)) dut (
        .rd_clk       (rd_clk),
        .rd_rst_n     (rd_rst_n),
        .wr_ptr_sync  (wr_ptr_sync),
        .bram_rd_addr (bram_rd_addr),
        .bram_rd_data (bram_rd_data),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .rd_ptr       (rd_ptr),
        .rd_ptr_gray  (rd_ptr_gray),
        .rd_level     (rd_level)
    );

    always #5 rd_clk = ~rd_clk;

    // The BRAM has a one-cycle registered read.
    logic [7:0] mem [D];
    always @(posedge rd_clk) bram_rd_data <= mem[bram_rd_addr];

    // Scoreboard state: the words written but not yet consumed, in order.
    logic [7:0]    exp_q [$];
    logic [PW-1:0] popped;
    logic [PW-1:0] prev_gray;
    logic [PW-1:0] prev_ptr;
    logic          prev_hold;
    bit            rand_data;
    int            total_push;
    int            total_pop;
    int            n_vec;
    int            n_err;

    // The writer never gets more than D words ahead of what has been consumed.
    always @(posedge rd_clk) begin
        if (rd_rst_n) begin
            assert (PW'(wr_ptr_sync - popped) <= PW'(D))
            else $error("wr_ptr_sync more than depth ahead of consumed words");
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Write up to n words into the memory model and advance the write pointer.
    task automatic push_words(input int n);
        logic [7:0] v;
        for (int i = 0; i < n; i++) begin
            if (PW'(wr_ptr_sync - popped) < PW'(D)) begin
                v = rand_data ? 8'($urandom) : wr_ptr_sync[7:0];
                mem[wr_ptr_sync[AB-1:0]] = v;
                exp_q.push_back(v);
                wr_ptr_sync = wr_ptr_sync + PW'(1);
                total_push++;
            end
        end
    endtask

    // One cycle: drive the inputs, then check the outputs against the scoreboard.
    task automatic step(input logic rdy, input int n);
        logic [PW-1:0] ahead;
        logic [PW-1:0] wr_dist;
        @(negedge rd_clk);
        push_words(n);
        m_ready = rdy;
        #1;
        ahead   = rd_ptr - popped;
        wr_dist = wr_ptr_sync - rd_ptr;
        check("addr", 32'(bram_rd_addr), 32'(rd_ptr[AB-1:0]));
        check("level", 32'(rd_level), 32'(PW'(wr_ptr_sync - popped)));
        check("gray_hd", 32'($countones(rd_ptr_gray ^ prev_gray)), (rd_ptr != prev_ptr) ? 32'd1 : 32'd0);
        check("ahead", 32'(ahead <= PW'(2)), 32'd1);
        check("wr_dist", 32'(wr_dist <= PW'(D)), 32'd1);
        if (prev_hold) check("hold_vld", 32'(m_valid), 32'd1);
        if (m_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious", 32'(m_valid), 32'd0);
            end else begin
                check("data", 32'(m_data), 32'(exp_q[0]));
                if (m_ready) begin
                    void'(exp_q.pop_front());
                    popped = popped + PW'(1);
                    total_pop++;
                end
            end
        end
        prev_hold = m_valid && !m_ready;
        prev_gray = rd_ptr_gray;
        prev_ptr  = rd_ptr;
    endtask

    // Reset for n edges (the write side restarts with it), then check reset values.
    task automatic do_reset(input int n);
        @(negedge rd_clk);
        rd_rst_n    = 1'b0;
        m_ready     = 1'b0;
        wr_ptr_sync = '0;
        exp_q.delete();
        popped    = '0;
        prev_hold = 1'b0;
        prev_gray = '0;
        prev_ptr  = '0;
        total_push = 0;
        total_pop  = 0;
        repeat (n) @(negedge rd_clk);
        #1;
        check("rst_vld", 32'(m_valid), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_ptr", 32'(rd_ptr), 32'd0);
        check("rst_gray", 32'(rd_ptr_gray), 32'd0);
        check("rst_level", 32'(rd_level), 32'd0);
        check("rst_addr", 32'(bram_rd_addr), 32'd0);
        rd_rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int start_pop;
        bit saw_wrap;
        n_vec = 0;
        n_err = 0;
        rand_data = 1'b0;
        popped = '0;
        total_push = 0;
        total_pop = 0;
        for (int i = 0; i < D; i++) mem[i] = 8'h00;

        // Idle after reset: nothing to read.
        do_reset(2);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 0);
            check("idle_vld", 32'(m_valid), 32'd0);
            check("idle_addr", 32'(bram_rd_addr), 32'd0);
            check("idle_level", 32'(rd_level), 32'd0);
            check("idle_gray", 32'(rd_ptr_gray), 32'd0);
        end

        // First-word latency and a back-to-back stream of 0x00..0x07.
        step(1'b1, 8);
        check("lat0_vld", 32'(m_valid), 32'd0);
        step(1'b1, 0);
        check("lat1_vld", 32'(m_valid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 0);
            check("stream_vld", 32'(m_valid), 32'd1);
        end
        step(1'b1, 0);
        check("end_vld", 32'(m_valid), 32'd0);
        check("end_ptr", 32'(rd_ptr), 32'd8);
        check("end_level", 32'(rd_level), 32'd0);
        check("end_cnt", 32'(total_pop), 32'd8);

        // Backpressure: reads stop two words ahead, and release delivers without gaps.
        do_reset(2);
        step(1'b0, 8);
        repeat (5) step(1'b0, 0);
        check("bp_vld", 32'(m_valid), 32'd1);
        check("bp_data", 32'(m_data), 32'h00);
        check("bp_ptr", 32'(rd_ptr), 32'd2);
        check("bp_level", 32'(rd_level), 32'd8);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 0);
            check("bp_rel_vld", 32'(m_valid), 32'd1);
        end
        step(1'b1, 0);
        check("bp_end_vld", 32'(m_valid), 32'd0);
        check("bp_end_cnt", 32'(total_pop), 32'd8);

        // 1500 random words with random m_ready, crossing the pointer wrap.
        do_reset(2);
        rand_data = 1'b1;
        saw_wrap = 1'b0;
        cyc = 0;
        while (cyc < 20000 && total_pop < 1500) begin
            step(logic'($urandom_range(0, 2) != 0),
                 (total_push < 1500) ? $urandom_range(0, 3) : 0);
            if (rd_ptr[AB] && rd_ptr[AB-1:0] == '0) saw_wrap = 1'b1;
            cyc++;
        end
        check("rand_cnt", 32'(total_pop), 32'd1500);
        check("rand_wrap", 32'(saw_wrap), 32'd1);

        // Completely full memory: level equals the depth, and every word is readable.
        repeat (4) step(1'b1, 0);
        start_pop = total_pop;
        step(1'b0, D);
        check("full_level", 32'(rd_level), 32'(D));
        repeat (4) step(1'b0, 0);
        check("full_level2", 32'(rd_level), 32'(D));
        check("full_vld", 32'(m_valid), 32'd1);
        cyc = 0;
        while (cyc < 3000 && exp_q.size() != 0) begin
            step(1'b1, 0);
            cyc++;
        end
        check("full_drain", 32'(total_pop - start_pop), 32'(D));
        step(1'b1, 0);
        check("full_end_level", 32'(rd_level), 32'd0);

        // Reset with the buffer full: no stale word afterwards.
        rand_data = 1'b0;
        do_reset(2);
        step(1'b0, 8);
        repeat (4) step(1'b0, 0);
        do_reset(1);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 0);
            check("nostale_a", 32'(m_valid), 32'd0);
        end

        // Reset with a read in flight.
        do_reset(2);
        step(1'b0, 8);
        repeat (4) step(1'b0, 0);
        step(1'b1, 0);
        do_reset(1);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 0);
            check("nostale_b", 32'(m_valid), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
